// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for the pipelined MIPS core.
// Two prioritised write ports (port 1 wins on equal address), NRD
// combinational read ports, optional hardwired-zero entry 0, and a
// sequential clear engine that zeroes one entry per cycle after reset
// or on clr_req.
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write
// data to the read ports (write-to-read in the write cycle). Without it
// reads return array contents only.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | normal operation, writes commit, reads return array/bypass
// CLEAR | clear engine zeroes mem[cnt] each cycle, writes dropped,
//       | reads return 0, busy=1

module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [WIDTH-1:0]      wdata0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [WIDTH-1:0]      wdata1,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic wr0_zero;
  logic wr1_zero;
  logic wr_collide;
  logic wr0_ok;
  logic wr1_ok;

  assign busy = (state == CLEAR);

  // Write qualification: zero-register discard and port-1 priority on collision.
  always_comb begin
    wr0_zero   = HAS_ZERO && (waddr0 == '0);
    wr1_zero   = HAS_ZERO && (waddr1 == '0);
    wr_collide = we1 && (waddr1 == waddr0);
    wr0_ok     = we0 && !wr0_zero && !wr_collide;
    wr1_ok     = we1 && !wr1_zero;
  end

  // Clear-engine sequencing: reset and clr_req both restart the sweep at entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Array update: one entry zeroed per clear cycle, otherwise the two write ports.
  // The reset edge itself leaves the array alone; the sweep does the clearing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else begin
        if (wr0_ok) mem[waddr0] <= wdata0;
        if (wr1_ok) mem[waddr1] <= wdata1;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [WIDTH-1:0]  rd;
    logic              ra_zero;

    assign ra      = raddr[i*ADDR_W +: ADDR_W];
    assign ra_zero = HAS_ZERO && (ra == '0);

    // Read port: array, optionally overridden by bypass, then zero-reg, then busy.
    always_comb begin
      rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (we1 && (waddr1 == ra)) begin
        rd = wdata1;
      end else if (we0 && (waddr0 == ra)) begin
        rd = wdata0;
      end
`endif
      if (ra_zero) rd = '0;
      if (busy)    rd = '0;
    end

    assign rdata[i*WIDTH +: WIDTH] = rd;
  end

endmodule
